// File: rtl/state_dump.sv
// state_dump: post-run register/memory readout serialized as a framed byte stream.
// Optional trailing checksum byte enabled by defining DUMP_CHECKSUM_EN.
module state_dump #(
    parameter int         NUM_REGS = 32,
    parameter int         NUM_MEM  = 32,
    parameter logic [7:0] HEADER   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        rd_en,
    output logic [5:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [5:0] LAST = 6'(NUM_REGS + NUM_MEM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_FETCH,
        S_WAIT,
        S_SEND,
        S_CSUM,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  widx_q, widx_d;
    logic [1:0]  bidx_q, bidx_d;
    logic [31:0] shreg_q, shreg_d;
    logic [5:0]  addr_q, addr_d;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    // State and datapath registers; async reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            widx_q  <= '0;
            bidx_q  <= '0;
            shreg_q <= '0;
            addr_q  <= '0;
`ifdef DUMP_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            bidx_q  <= bidx_d;
            shreg_q <= shreg_d;
            addr_q  <= addr_d;
`ifdef DUMP_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Next-state and outputs; all outputs decode from registered state.
    always_comb begin
        state_d  = state_q;
        widx_d   = widx_q;
        bidx_d   = bidx_q;
        shreg_d  = shreg_q;
        addr_d   = addr_q;
`ifdef DUMP_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        rd_en    = 1'b0;
        rd_addr  = addr_q;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_HDR;
                    widx_d  = '0;
`ifdef DUMP_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_HDR: begin
                tx_valid = 1'b1;
                tx_data  = HEADER;
                if (tx_ready) state_d = S_FETCH;
            end
            S_FETCH: begin
                rd_en   = 1'b1;
                rd_addr = widx_q;
                addr_d  = widx_q;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                shreg_d = rd_data;
                bidx_d  = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                tx_valid = 1'b1;
                tx_data  = shreg_q[7:0];
                if (tx_ready) begin
`ifdef DUMP_CHECKSUM_EN
                    csum_d = csum_q + shreg_q[7:0];
`endif
                    if (bidx_q != 2'd3) begin
                        shreg_d = {8'h00, shreg_q[31:8]};
                        bidx_d  = bidx_q + 2'd1;
                    end else if (widx_q != LAST) begin
                        widx_d  = widx_q + 6'd1;
                        state_d = S_FETCH;
                    end else begin
`ifdef DUMP_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            S_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum_q;
                if (tx_ready) state_d = S_DONE;
            end
`endif
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_state_dump.sv
// tb_state_dump: directed self-checking bench for state_dump.
// Checksum expectations follow DUMP_CHECKSUM_EN.
module tb_state_dump;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        tx_ready = 1'b1;
    logic [31:0] rd_data = 32'h0;
    logic        rd_en, tx_valid, busy, done;
    logic [5:0]  rd_addr;
    logic [7:0]  tx_data;

    state_dump dut (
        .clk(clk), .rst(rst), .start(start),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

`ifdef DUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int FLEN = 257 + CS;
    localparam int LAST_CYC = 1 + 64 * 6 + CS;

    logic [31:0] wmem [64];
    logic [7:0]  got [$];
    logic [7:0]  exp_q [$];

    // Synchronous read port model: data one cycle after rd_en.
    always @(posedge clk) if (rd_en) rd_data <= wmem[rd_addr];

    int tests = 0;
    int fails = 0;
    int done_cnt, done_cyc, last_cyc, fetch_cyc;
    int addr_err, stall_err, hold_err, exp_addr;
    logic busy_after, first_valid;
    logic [7:0] first_data;

    task automatic set_pattern(input int p);
        for (int i = 0; i < 64; i++) begin
            case (p)
                0: wmem[i] = (i < 32) ? 32'(i) * 32'h01010101
                                      : 32'hDEAD0000 + 32'(i - 32);
                1: wmem[i] = 32'hFFFFFFFF;
                2: wmem[i] = 32'h00000001;
                default: wmem[i] = 32'(i) * 32'h9E3779B1;
            endcase
        end
    endtask

    task automatic build_exp();
        logic [7:0] s;
        logic [31:0] w;
        s = 8'h00;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 64; i++) begin
            w = wmem[i];
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(w[8*b +: 8]);
                s = s + w[8*b +: 8];
            end
        end
        if (CS == 1) exp_q.push_back(s);
    endtask

    function automatic int stream_diff();
        int n = 0;
        if (got.size() != exp_q.size()) n++;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (got[i] !== exp_q[i]) n++;
        return n;
    endfunction

    // mode 0: tx_ready=1; mode 1: random ready.
    task automatic run_frame(input int mode, input int restart_at,
                             input int abort_at);
        logic pv, pr;
        logic [7:0] pd;
        logic [5:0] la;
        bit restarted;
        pv = 1'b0; pr = 1'b0; pd = 8'h00; restarted = 1'b0;
        done_cnt = 0; done_cyc = 0; last_cyc = 0; fetch_cyc = 0;
        addr_err = 0; stall_err = 0; hold_err = 0; exp_addr = 0;
        busy_after = 1'bx;
        got.delete();
        @(negedge clk);
        la = rd_addr;
        start = 1'b1;
        tx_ready = 1'b1;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            tx_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (cyc == 1) begin
                first_valid = tx_valid;
                first_data  = tx_data;
            end
            if (pv && !pr && (!tx_valid || tx_data !== pd)) stall_err++;
            if (rd_en) begin
                if (fetch_cyc == 0) fetch_cyc = cyc;
                if (int'(rd_addr) != exp_addr) addr_err++;
                exp_addr++;
                la = rd_addr;
            end else if (rd_addr !== la) begin
                hold_err++;
            end
            if (abort_at >= 0 && tx_valid && got.size() == abort_at) begin
                rst = 1'b0;
                #1;
                return;
            end
            if (tx_valid && tx_ready) begin
                got.push_back(tx_data);
                last_cyc = cyc;
            end
            if (restart_at >= 0 && !restarted && got.size() == restart_at) begin
                start = 1'b1;
                restarted = 1'b1;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (done_cyc > 0 && cyc == done_cyc + 1) busy_after = busy;
            if (done_cyc > 0 && cyc == done_cyc + 4) break;
            pv = tx_valid; pr = tx_ready; pd = tx_data;
        end
        tx_ready = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL rst_tx_valid got %b want 0", tx_valid); end
        tests++; if (rd_en !== 1'b0) begin fails++; $display("FAIL rst_rd_en got %b want 0", rd_en); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done got %b want 0", done); end
        tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
        tests++; if (rd_addr !== 6'd0) begin fails++; $display("FAIL rst_rd_addr got %0d want 0", rd_addr); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin fails++; $display("FAIL idle_after_rst busy %b valid %b want 0 0", busy, tx_valid); end
    endtask

    task automatic test_pattern();
        logic [31:0] w;
        set_pattern(0);
        build_exp();
        run_frame(0, -1, -1);
        tests++; if (done_cyc == 0) begin fails++; $display("FAIL pat_timeout no done seen"); end
        tests++; if (first_valid !== 1'b1 || first_data !== 8'hA5) begin fails++; $display("FAIL pat_hdr valid %b data %h want 1 a5", first_valid, first_data); end
        tests++; if (fetch_cyc != 2) begin fails++; $display("FAIL pat_fetch_cyc got %0d want 2", fetch_cyc); end
        tests++; if (got.size() != FLEN) begin fails++; $display("FAIL pat_len got %0d want %0d", got.size(), FLEN); end
        tests++;
        if (got.size() < 257) begin
            fails++; $display("FAIL pat_bytes short frame %0d", got.size());
        end else begin
            w = {got[8], got[7], got[6], got[5]};
            if ({got[4], got[3], got[2], got[1]} !== 32'h0 || w !== 32'h01010101
                || {got[256], got[255], got[254], got[253]} !== 32'hDEAD001F) begin
                fails++;
                $display("FAIL pat_bytes w0 %h w1 %h w63 %h want 0 01010101 dead001f",
                         {got[4], got[3], got[2], got[1]}, w,
                         {got[256], got[255], got[254], got[253]});
            end
        end
        tests++; if (stream_diff() != 0) begin fails++; $display("FAIL pat_stream %0d diffs want 0", stream_diff()); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL pat_done_cnt got %0d want 1", done_cnt); end
        tests++; if (busy_after !== 1'b0) begin fails++; $display("FAIL pat_busy_fall got %b want 0", busy_after); end
        tests++; if (last_cyc != LAST_CYC) begin fails++; $display("FAIL pat_last_cyc got %0d want %0d", last_cyc, LAST_CYC); end
        tests++; if (done_cyc != last_cyc + 1) begin fails++; $display("FAIL pat_done_cyc got %0d want %0d", done_cyc, last_cyc + 1); end
        tests++; if (addr_err != 0 || exp_addr != 64) begin fails++; $display("FAIL pat_addr err %0d reads %0d want 0 64", addr_err, exp_addr); end
        tests++; if (hold_err != 0) begin fails++; $display("FAIL pat_addr_hold got %0d want 0", hold_err); end
    endtask

    task automatic test_stall();
        set_pattern(0);
        build_exp();
        run_frame(1, -1, -1);
        tests++; if (stream_diff() != 0) begin fails++; $display("FAIL stall_stream %0d diffs want 0", stream_diff()); end
        tests++; if (stall_err != 0) begin fails++; $display("FAIL stall_hold got %0d want 0", stall_err); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL stall_done_cnt got %0d want 1", done_cnt); end
        tests++; if (hold_err != 0 || addr_err != 0) begin fails++; $display("FAIL stall_addr hold %0d seq %0d want 0 0", hold_err, addr_err); end
    endtask

    task automatic test_back_to_back();
        set_pattern(3);
        build_exp();
        run_frame(0, 41, -1);
        tests++; if (stream_diff() != 0) begin fails++; $display("FAIL restart_stream %0d diffs want 0", stream_diff()); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL restart_done_cnt got %0d want 1", done_cnt); end
        tests++; if (busy_after !== 1'b0) begin fails++; $display("FAIL restart_busy got %b want 0", busy_after); end
    endtask

    task automatic test_abort();
        set_pattern(3);
        build_exp();
        run_frame(0, -1, 83);
        tests++; if (rst !== 1'b0) begin fails++; $display("FAIL abort_reached abort point not hit"); end
        tests++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0
            || done !== 1'b0 || tx_data !== 8'h00 || rd_addr !== 6'd0) begin
            fails++;
            $display("FAIL abort_outputs valid %b busy %b rd_en %b done %b data %h addr %0d want all 0",
                     tx_valid, busy, rd_en, done, tx_data, rd_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL abort_no_done done %b busy %b want 0 0", done, busy); end
        set_pattern(0);
        build_exp();
        run_frame(0, -1, -1);
        tests++; if (stream_diff() != 0 || got.size() == 0 || got[0] !== 8'hA5) begin fails++; $display("FAIL abort_reframe %0d diffs want 0", stream_diff()); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL abort_done_cnt got %0d want 1", done_cnt); end
    endtask

`ifdef DUMP_CHECKSUM_EN
    task automatic test_checksum();
        set_pattern(1);
        run_frame(0, -1, -1);
        tests++; if (got.size() != 258 || got[257] !== 8'h00) begin fails++; $display("FAIL csum_ff size %0d last %h want 258 00", got.size(), got.size() > 0 ? got[got.size()-1] : 8'hxx); end
        set_pattern(2);
        run_frame(0, -1, -1);
        tests++; if (got.size() != 258 || got[257] !== 8'h40) begin fails++; $display("FAIL csum_01 size %0d last %h want 258 40", got.size(), got.size() > 0 ? got[got.size()-1] : 8'hxx); end
    endtask
`else
    task automatic test_no_checksum();
        set_pattern(2);
        run_frame(0, -1, -1);
        tests++; if (got.size() != 257) begin fails++; $display("FAIL nocsum_len got %0d want 257", got.size()); end
        tests++; if (got.size() < 254 || got[253] !== 8'h01 || got[got.size()-1] !== 8'h00) begin fails++; $display("FAIL nocsum_tail size %0d want word63 01 00 00 00", got.size()); end
        tests++; if (done_cyc != 386) begin fails++; $display("FAIL nocsum_done_cyc got %0d want 386", done_cyc); end
    endtask
`endif

    initial begin
        test_reset();
        test_pattern();
        test_stall();
        test_back_to_back();
        test_abort();
`ifdef DUMP_CHECKSUM_EN
        test_checksum();
`else
        test_no_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/state_dump.md
# state_dump

Post-run state readout unit for the multi-cycle RISC-V datapath. After the core reaches its finish state, it reads all 32 architectural registers and all 32 data-memory words through a synchronous read port. It then serializes them as a framed byte stream on a valid/ready interface toward the host/testbench link. It consumes the register and memory state that the datapath produces.

## Interface
- NUM_REGS, 32, register words dumped; indices 0..NUM_REGS-1 on the read port
- NUM_MEM, 32, memory words dumped; indices NUM_REGS..NUM_REGS+NUM_MEM-1
- HEADER, 8'hA5, first byte of every frame
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a dump, typically raised when the core enters its finish state
- rd_en  out  1  read strobe to register/memory read mux
- rd_addr  out  6  word index: 0-31 registers x0..x31, 32-63 memory words 0..31
- rd_data  in  32  word for rd_addr; valid exactly one cycle after rd_en
- tx_data  out  8  stream byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts; a transfer occurs on a posedge with tx_valid && tx_ready
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last byte of a frame is accepted

## Operation
- Frame: HEADER, then 64 words in index order, each as 4 bytes little-endian (bits 7:0 first), then the optional checksum byte.
- States:
  - IDLE: start -> HDR.
  - HDR: tx_valid=1, tx_data=HEADER; on transfer -> FETCH.
  - FETCH: rd_en=1 and rd_addr=word index for one cycle -> WAIT.
  - WAIT: capture rd_data into the 32-bit shift register, clear byte index -> SEND.
  - SEND: present the current byte. On transfer, if byte index<3, shift and increment. Otherwise, if word index<63, increment word index and go to FETCH; else go to CSUM or DONE.
  - CSUM: present the checksum; on transfer -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- The checksum is an 8-bit sum, mod 256, of all 256 payload bytes. It excludes HEADER and is cleared at start.
- start is ignored in every state other than IDLE.
- tx_data is stable while tx_valid && !tx_ready. tx_valid never drops before a transfer completes.
- busy=1 in every state except IDLE. rd_addr holds its last value when rd_en=0.
- Reset values: state IDLE; tx_valid, rd_en, busy, done all 0; tx_data 0; rd_addr 0; checksum 0.
- Reset asserted mid-frame aborts the frame immediately. No done pulse is issued. The next frame restarts from HEADER.

## Timing
- start sampled at edge N -> HDR with tx_valid=1 after edge N (cycle N+1).
- HEADER accepted at edge T -> rd_en high in cycle T+1 -> rd_data captured at edge T+2 -> byte0 valid in cycle T+2.
- Each word costs 2 overhead cycles plus 4 transfers. With tx_ready held at 1, the full frame (with checksum) is 1+64*6+1 = 386 cycles from HDR entry to the last transfer. done is high the following cycle.
- The word index wraps only by terminating the frame; no index 64 read is ever issued.

## Configuration
- DUMP_CHECKSUM_EN defined: CSUM state present; frame is 258 bytes.
- DUMP_CHECKSUM_EN undefined: no checksum logic; SEND goes directly to DONE after the last byte of word 63; frame is 257 bytes.

## Test plan
- Registers = index*0x01010101, memory = 0xDEAD0000+index, tx_ready=1, start pulse -> stream is A5, 00 00 00 00, 01 01 01 01, ..., 1F 00 AD DE. done pulses once and busy falls with it.
- All words 0xFFFFFFFF, checksum enabled -> last byte = (256*0xFF) mod 256 = 0x00. All words 0x00000001 -> checksum 0x40.
- tx_ready toggled pseudo-randomly -> tx_data/tx_valid held during stalls; byte sequence identical to the tx_ready=1 run.
- start pulsed again while busy (e.g. during word 10) -> ignored; exactly one frame and one done pulse.
- rst driven low during word 20 byte 2 -> outputs at reset values within the same cycle. A later start produces a complete frame beginning with A5.
- Built without DUMP_CHECKSUM_EN -> 257 bytes; done in the cycle after word 63 byte 3 is accepted.
